// File: rtl/race_pkg.sv
// Shared race encodings and countdown helpers used by race_director and the HUD.
package race_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CNT3 = 3'd1,
        ST_CNT2 = 3'd2,
        ST_CNT1 = 3'd3,
        ST_RACE = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_t;

    localparam logic [15:0] TIME_INVALID = 16'hFFFF;
    localparam int          CS_PER_SEC   = 100;

    function automatic state_t count_next(input state_t s);
        case (s)
            ST_CNT3: return ST_CNT2;
            ST_CNT2: return ST_CNT1;
            default: return ST_RACE;
        endcase
    endfunction

    function automatic logic [1:0] count_digit(input state_t s);
        case (s)
            ST_CNT3: return 2'd3;
            ST_CNT2: return 2'd2;
            ST_CNT1: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cs_tick_gen.sv
// Centisecond tick: one-cycle pulse every CLK_FREQ/100 cycles, realignable via restart.
module cs_tick_gen
    import race_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            PERIOD = CLK_FREQ / CS_PER_SEC;
    localparam int            CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] TERM   = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/race_director.sv
// Race sequencer: countdown, race timing, finish capture and winner decision.
// Optional build macro RACE_TIMEOUT_EN ends a race after MAX_RACE_CS centiseconds.
module race_director
    import race_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int COUNT_CS    = 100
`ifdef RACE_TIMEOUT_EN
    ,
    parameter int MAX_RACE_CS = 18000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        p1_finish,
    input  logic        p2_finish,
    output logic [2:0]  state,
    output logic        car_rst,
    output logic [1:0]  countdown,
    output logic [15:0] race_cs,
    output logic [15:0] p1_time_cs,
    output logic [15:0] p2_time_cs,
    output logic [1:0]  winner
);

    state_t      st;
    winner_t     win;
    logic [15:0] step_cnt;
    logic        start_q, p1_q, p2_q;
    logic        start_rise, p1_rise, p2_rise, rec1, rec2;
    logic        tick, restart, counting, step_end, both_done, timeout, race_end;

    assign state  = st;
    assign winner = win;

    // The start register follows the button even in reset, so a button held
    // through reset reads as already pressed and cannot start a race.
    always_ff @(posedge clk) begin
        start_q <= start_btn;
        p1_q    <= p1_finish;
        p2_q    <= p2_finish;
    end

    assign start_rise = start_btn & ~start_q;
    assign p1_rise    = p1_finish & ~p1_q;
    assign p2_rise    = p2_finish & ~p2_q;
    assign rec1       = (st == ST_RACE) && p1_rise && (p1_time_cs == TIME_INVALID);
    assign rec2       = (st == ST_RACE) && p2_rise && (p2_time_cs == TIME_INVALID);

    assign counting  = (st == ST_CNT3) || (st == ST_CNT2) || (st == ST_CNT1);
    assign step_end  = counting && tick && (step_cnt == 16'(COUNT_CS - 1));
    assign both_done = (p1_time_cs != TIME_INVALID) && (p2_time_cs != TIME_INVALID);

`ifdef RACE_TIMEOUT_EN
    assign timeout = (race_cs >= 16'(MAX_RACE_CS));
`else
    assign timeout = 1'b0;
`endif

    assign race_end = (st == ST_RACE) && (both_done || timeout);
    assign restart  = (start_rise && ((st == ST_IDLE) || (st == ST_DONE)))
                    || step_end || race_end;

    cs_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            car_rst    <= 1'b0;
            countdown  <= 2'd0;
            race_cs    <= 16'd0;
            p1_time_cs <= TIME_INVALID;
            p2_time_cs <= TIME_INVALID;
            win        <= WIN_NONE;
            step_cnt   <= 16'd0;
        end else begin
            car_rst <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start_rise) begin
                        st         <= ST_CNT3;
                        car_rst    <= 1'b1;
                        countdown  <= count_digit(ST_CNT3);
                        race_cs    <= 16'd0;
                        p1_time_cs <= TIME_INVALID;
                        p2_time_cs <= TIME_INVALID;
                        win        <= WIN_NONE;
                        step_cnt   <= 16'd0;
                    end
                end
                ST_CNT3, ST_CNT2, ST_CNT1: begin
                    if (step_end) begin
                        st        <= count_next(st);
                        countdown <= count_digit(count_next(st));
                        step_cnt  <= 16'd0;
                    end else if (tick) begin
                        step_cnt <= step_cnt + 16'd1;
                    end
                end
                ST_RACE: begin
                    if (tick && (race_cs != TIME_INVALID)) begin
                        race_cs <= race_cs + 16'd1;
                    end
                    // Recorded times are the pre-increment value of this cycle.
                    if (rec1) p1_time_cs <= race_cs;
                    if (rec2) p2_time_cs <= race_cs;
                    if (win == WIN_NONE) begin
                        if (rec1 && rec2) win <= WIN_DRAW;
                        else if (rec1)    win <= WIN_P1;
                        else if (rec2)    win <= WIN_P2;
                    end
                    if (race_end) begin
                        st <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start_rise) begin
                        st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_race_director.sv
// Scoreboard bench for race_director: expected state-change events are queued by
// the stimulus and popped by a monitor whenever the DUT changes state.
module tb_race_director;

    localparam logic [15:0] INV = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst, start_btn, p1_finish, p2_finish;
    logic [2:0]  state;
    logic        car_rst;
    logic [1:0]  countdown, winner;
    logic [15:0] race_cs, p1_time_cs, p2_time_cs;

    logic        a_rst, a_start, a_p1, a_p2;
    logic [2:0]  a_state;
    logic        a_car_rst;
    logic [1:0]  a_countdown, a_winner;
    logic [15:0] a_race_cs, a_p1_time, a_p2_time;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit aux_done = 1'b0;

    typedef struct {
        logic [2:0]  st;
        logic [1:0]  cd;
        logic [15:0] rcs;
        logic [15:0] t1;
        logic [15:0] t2;
        logic [1:0]  win;
        logic        crst;
        int          dur;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    race_director #(
        .CLK_FREQ (1000),
        .COUNT_CS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_btn  (start_btn),
        .p1_finish  (p1_finish),
        .p2_finish  (p2_finish),
        .state      (state),
        .car_rst    (car_rst),
        .countdown  (countdown),
        .race_cs    (race_cs),
        .p1_time_cs (p1_time_cs),
        .p2_time_cs (p2_time_cs),
        .winner     (winner)
    );

`ifdef RACE_TIMEOUT_EN
    race_director #(
        .CLK_FREQ    (1000),
        .COUNT_CS    (2),
        .MAX_RACE_CS (50)
    ) aux (
`else
    race_director #(
        .CLK_FREQ (100),
        .COUNT_CS (2)
    ) aux (
`endif
        .clk        (clk),
        .rst        (a_rst),
        .start_btn  (a_start),
        .p1_finish  (a_p1),
        .p2_finish  (a_p2),
        .state      (a_state),
        .car_rst    (a_car_rst),
        .countdown  (a_countdown),
        .race_cs    (a_race_cs),
        .p1_time_cs (a_p1_time),
        .p2_time_cs (a_p2_time),
        .winner     (a_winner)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [1:0] cd, input logic [15:0] rcs,
                        input logic [15:0] t1, input logic [15:0] t2, input logic [1:0] win,
                        input logic crst, input int dur, input string tag);
        exp_t e;
        e.st = st; e.cd = cd; e.rcs = rcs; e.t1 = t1; e.t2 = t2;
        e.win = win; e.crst = crst; e.dur = dur; e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: one scoreboard pop per observed state change.
    logic [2:0] prev_st;
    int         run = 0;
    bit         first = 1'b1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (first || (state != prev_st)) begin
                exp_t e;
                int   dur_seen;
                dur_seen = run;
                run = 1;
                first = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event state=%0d expected=no_event", state);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, ".state"},     state,      e.st);
                    chk({e.tag, ".countdown"}, countdown,  e.cd);
                    chk({e.tag, ".race_cs"},   race_cs,    e.rcs);
                    chk({e.tag, ".p1_time"},   p1_time_cs, e.t1);
                    chk({e.tag, ".p2_time"},   p2_time_cs, e.t2);
                    chk({e.tag, ".winner"},    winner,     e.win);
                    chk({e.tag, ".car_rst"},   car_rst,    e.crst);
                    if (e.dur >= 0) chk({e.tag, ".dur"}, dur_seen, e.dur);
                end
            end else begin
                run++;
                chk("car_rst_stray", car_rst, 0);
            end
            prev_st = state;
        end
    end

    task automatic press();
        start_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rcs(input logic [15:0] v);
        int i;
        for (i = 0; i < 3000 && race_cs != v; i++) @(negedge clk);
        if (race_cs != v) begin
            checks++;
            errors++;
            $display("FAIL wait_race_cs actual=%0d expected=%0d", race_cs, v);
        end
    endtask

    task automatic wait_state(input logic [2:0] s);
        int i;
        for (i = 0; i < 3000 && state != s; i++) @(negedge clk);
        if (state != s) begin
            checks++;
            errors++;
            $display("FAIL wait_state actual=%0d expected=%0d", state, s);
        end
    endtask

    task automatic push_countdown(input string tag);
        push(3'd1, 2'd3, 16'd0, INV, INV, 2'd0, 1'b1, -1, {tag, "_cnt3"});
        push(3'd2, 2'd2, 16'd0, INV, INV, 2'd0, 1'b0, 20, {tag, "_cnt2"});
        push(3'd3, 2'd1, 16'd0, INV, INV, 2'd0, 1'b0, 20, {tag, "_cnt1"});
        push(3'd4, 2'd0, 16'd0, INV, INV, 2'd0, 1'b0, 20, {tag, "_race"});
    endtask

    initial begin
        rst = 1'b1; start_btn = 1'b0; p1_finish = 1'b0; p2_finish = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(3'd0, 2'd0, 16'd0, INV, INV, 2'd0, 1'b0, -1, "reset");
        @(posedge clk);
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Race 1: car 1 at 37, car 2 at 52.
        push_countdown("r1");
        push(3'd5, 2'd0, 16'd52, 16'd37, 16'd52, 2'd1, 1'b0, -1, "r1_done");
        press();
        wait_rcs(16'd37); p1_finish = 1'b1;
        wait_rcs(16'd52); p2_finish = 1'b1;
        wait_state(3'd5);
        @(negedge clk); p1_finish = 1'b0; p2_finish = 1'b0;
        repeat (4) @(negedge clk);

        // Race 2: simultaneous finish at 40.
        push(3'd0, 2'd0, 16'd52, 16'd37, 16'd52, 2'd1, 1'b0, -1, "r2_idle");
        press();
        push_countdown("r2");
        push(3'd5, 2'd0, 16'd40, 16'd40, 16'd40, 2'd3, 1'b0, -1, "r2_done");
        press();
        wait_rcs(16'd40); p1_finish = 1'b1; p2_finish = 1'b1;
        wait_state(3'd5);
        @(negedge clk); p1_finish = 1'b0; p2_finish = 1'b0;
        repeat (4) @(negedge clk);

        // Race 3: car 2 level high before the race does not count.
        push(3'd0, 2'd0, 16'd40, 16'd40, 16'd40, 2'd3, 1'b0, -1, "r3_idle");
        press();
        push_countdown("r3");
        push(3'd5, 2'd0, 16'd15, 16'd10, 16'd15, 2'd1, 1'b0, -1, "r3_done");
        press();
        p2_finish = 1'b1;
        wait_rcs(16'd10); p1_finish = 1'b1;
        wait_rcs(16'd12); p2_finish = 1'b0;
        wait_rcs(16'd15); p2_finish = 1'b1;
        wait_state(3'd5);
        @(negedge clk); p1_finish = 1'b0; p2_finish = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during CNT2 with the button held through it.
        push(3'd0, 2'd0, 16'd15, 16'd10, 16'd15, 2'd1, 1'b0, -1, "r4_idle");
        press();
        push(3'd1, 2'd3, 16'd0, INV, INV, 2'd0, 1'b1, -1, "r4_cnt3");
        push(3'd2, 2'd2, 16'd0, INV, INV, 2'd0, 1'b0, 20, "r4_cnt2");
        push(3'd0, 2'd0, 16'd0, INV, INV, 2'd0, 1'b0, -1, "rst_cnt2");
        press();
        wait_state(3'd2);
        repeat (5) @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (30) @(negedge clk);
        start_btn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during RACE at 20 with the button held through it.
        push_countdown("r5");
        push(3'd0, 2'd0, 16'd0, INV, INV, 2'd0, 1'b0, -1, "rst_race");
        press();
        wait_rcs(16'd20);
        start_btn = 1'b1; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (30) @(negedge clk);
        start_btn = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 90000 && !aux_done; i++) @(negedge clk);
        if (!aux_done) begin
            checks++;
            errors++;
            $display("FAIL aux_timeout actual=running expected=done");
        end
        chk("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Auxiliary instance: timeout (with macro) or race_cs saturation (without).
    initial begin
        int i;
        a_rst = 1'b1; a_start = 1'b0; a_p1 = 1'b0; a_p2 = 1'b0;
        repeat (3) @(negedge clk);
        a_rst = 1'b0;
        @(negedge clk);
        a_start = 1'b1;
`ifdef RACE_TIMEOUT_EN
        for (i = 0; i < 3000 && a_race_cs != 16'd50; i++) @(negedge clk);
        chk("to_reach50", a_race_cs, 50);
        chk("to_state_at50", a_state, 4);
        @(negedge clk);
        chk("to_state", a_state, 5);
        chk("to_winner", a_winner, 0);
        chk("to_p1_time", a_p1_time, INV);
        chk("to_p2_time", a_p2_time, INV);
        chk("to_race_cs", a_race_cs, 50);
`else
        for (i = 0; i < 70000 && a_race_cs != INV; i++) @(negedge clk);
        chk("sat_reach", a_race_cs, INV);
        repeat (5) @(negedge clk);
        chk("sat_race_cs", a_race_cs, INV);
        chk("sat_state", a_state, 4);
        chk("sat_winner", a_winner, 0);
`endif
        aux_done = 1'b1;
    end

endmodule
